image_blitter: RTL and testbench

- Parametrised full-image/sprite drawer for the VGA plot path. It is the successor to the fixed 160x120 splash, victory and death screen drawers.
- On a start pulse it latches an image select, a screen origin and a transparency mode. It then walks every pixel of the selected image ROM in raster order and emits (x, y, colour, plot) to the VGA adapter.
- It adds a start/busy/done handshake, ROM latency compensation, origin offset, edge clipping and colour-key transparency.

---
 rtl/image_blitter.sv | 180 ++++++++++++++++++
 tb/tb_image_blitter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_blitter.sv
// Raster-order image/sprite blitter for the VGA plot path: walks an external image ROM
// and emits clipped, colour-keyed (x, y, colour, plot) with a start/busy/done handshake.
module image_blitter #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int ADDR_W   = 15,
  parameter int COL_W    = 3,
  parameter int SEL_W    = 2,
  parameter int ROM_LAT  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  img_sel,
  input  logic [X_W-1:0]    x_origin,
  input  logic [Y_W-1:0]    y_origin,
  input  logic              key_en,
  input  logic [COL_W-1:0]  key_col,
  output logic [SEL_W-1:0]  rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COL_W-1:0]  rom_data,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic [COL_W-1:0]  out_col,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state, state_nx;
  logic [X_W-1:0]     lx;
  logic [Y_W-1:0]     ly;
  logic [1:0]         flush_cnt;
  logic [X_W-1:0]     x_org;
  logic [Y_W-1:0]     y_org;
  logic               key_on;
  logic [COL_W-1:0]   key_c;
  logic               accept;
  logic               last_addr;
  logic               issue_v;

  logic [X_W-1:0]     al_x;
  logic [Y_W-1:0]     al_y;
  logic               al_v;
  logic [X_W:0]       sx;
  logic [Y_W:0]       sy;
  logic               visible;

  always_comb begin
    accept    = (state == IDLE) && start;
    last_addr = (rom_addr == ADDR_W'(IMG_W*IMG_H-1));
    issue_v   = (state == RUN);
    busy      = (state == RUN) || (state == FLUSH);
    done      = (state == DONE);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_addr) state_nx = FLUSH;
      FLUSH:   if (flush_cnt == 2'(ROM_LAT)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Address issue side: rom_addr is an incrementing counter kept in step with lx/ly
  always_ff @(posedge clock) begin
    if (reset) begin
      rom_addr  <= '0;
      lx        <= '0;
      ly        <= '0;
      rom_sel   <= '0;
      x_org     <= '0;
      y_org     <= '0;
      key_on    <= 1'b0;
      key_c     <= '0;
      flush_cnt <= '0;
    end else begin
      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : '0;
      if (accept) begin
        rom_sel  <= img_sel;
        x_org    <= x_origin;
        y_org    <= y_origin;
        key_on   <= key_en;
        key_c    <= key_col;
        rom_addr <= '0;
        lx       <= '0;
        ly       <= '0;
      end else if (state == RUN && !last_addr) begin
        rom_addr <= rom_addr + ADDR_W'(1);
        if (lx == X_W'(IMG_W-1)) begin
          lx <= '0;
          ly <= ly + Y_W'(1);
        end else begin
          lx <= lx + X_W'(1);
        end
      end
    end
  end

  // Delay coordinates and valid by the ROM latency so they line up with rom_data
  generate
    if (ROM_LAT == 0) begin : g_nolat
      always_comb begin
        al_x = lx;
        al_y = ly;
        al_v = issue_v;
      end
    end else begin : g_lat
      logic [X_W-1:0]     dx [ROM_LAT];
      logic [Y_W-1:0]     dy [ROM_LAT];
      logic [ROM_LAT-1:0] dv;

      always_ff @(posedge clock) begin
        if (reset) begin
          dv <= '0;
          for (int unsigned i = 0; i < ROM_LAT; i++) begin
            dx[i] <= '0;
            dy[i] <= '0;
          end
        end else begin
          dv[0] <= issue_v;
          dx[0] <= lx;
          dy[0] <= ly;
          for (int unsigned i = 1; i < ROM_LAT; i++) begin
            dv[i] <= dv[i-1];
            dx[i] <= dx[i-1];
            dy[i] <= dy[i-1];
          end
        end
      end

      always_comb begin
        al_x = dx[ROM_LAT-1];
        al_y = dy[ROM_LAT-1];
        al_v = dv[ROM_LAT-1];
      end
    end
  endgenerate

  always_comb begin
    sx      = {1'b0, x_org} + {1'b0, al_x};
    sy      = {1'b0, y_org} + {1'b0, al_y};
    visible = al_v
            && (sx < (X_W+1)'(SCREEN_W))
            && (sy < (Y_W+1)'(SCREEN_H))
            && !(key_on && (rom_data == key_c));
  end

  // Coordinates and colour follow every valid pixel; plot alone carries clip/key result
  always_ff @(posedge clock) begin
    if (reset) begin
      out_x   <= '0;
      out_y   <= '0;
      out_col <= '0;
      plot    <= 1'b0;
    end else begin
      plot <= visible;
      if (al_v) begin
        out_x   <= sx[X_W-1:0];
        out_y   <= sy[Y_W-1:0];
        out_col <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_image_blitter.sv
// Self-checking bench for image_blitter: a default 160x120/ROM_LAT=1 instance and a small
// 8x4/ROM_LAT=3 instance, driven from a blit table plus random blits against a pixel model.
module tb_image_blitter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        reset;
  logic        start_a, start_b;
  logic [1:0]  img_sel;
  logic [7:0]  x_origin;
  logic [6:0]  y_origin;
  logic        key_en;
  logic [2:0]  key_col;

  logic [1:0]  a_rom_sel,  b_rom_sel;
  logic [14:0] a_rom_addr, b_rom_addr;
  logic [2:0]  a_rom_data, b_rom_data, b_p1, b_p2;
  logic [7:0]  a_out_x,    b_out_x;
  logic [6:0]  a_out_y,    b_out_y;
  logic [2:0]  a_out_col,  b_out_col;
  logic        a_plot, b_plot, a_busy, b_busy, a_done, b_done;

  image_blitter dut_a (
    .clock(clock), .reset(reset), .start(start_a), .img_sel(img_sel),
    .x_origin(x_origin), .y_origin(y_origin), .key_en(key_en), .key_col(key_col),
    .rom_sel(a_rom_sel), .rom_addr(a_rom_addr), .rom_data(a_rom_data),
    .out_x(a_out_x), .out_y(a_out_y), .out_col(a_out_col),
    .plot(a_plot), .busy(a_busy), .done(a_done)
  );

  image_blitter #(.IMG_W(8), .IMG_H(4), .ROM_LAT(3)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .img_sel(img_sel),
    .x_origin(x_origin), .y_origin(y_origin), .key_en(key_en), .key_col(key_col),
    .rom_sel(b_rom_sel), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .out_x(b_out_x), .out_y(b_out_y), .out_col(b_out_col),
    .plot(b_plot), .busy(b_busy), .done(b_done)
  );

  // External ROMs: colour = addr[2:0] ^ sel, with the instance's read latency
  always @(posedge clock) begin
    a_rom_data <= a_rom_addr[2:0] ^ {1'b0, a_rom_sel};
    b_p1       <= b_rom_addr[2:0] ^ {1'b0, b_rom_sel};
    b_p2       <= b_p1;
    b_rom_data <= b_p2;
  end

  logic        which;
  logic [14:0] m_rom_addr;
  logic [1:0]  m_rom_sel;
  logic [7:0]  m_out_x;
  logic [6:0]  m_out_y;
  logic [2:0]  m_out_col;
  logic        m_plot, m_busy, m_done;
  always_comb begin
    m_rom_addr = which ? b_rom_addr : a_rom_addr;
    m_rom_sel  = which ? b_rom_sel  : a_rom_sel;
    m_out_x    = which ? b_out_x    : a_out_x;
    m_out_y    = which ? b_out_y    : a_out_y;
    m_out_col  = which ? b_out_col  : a_out_col;
    m_plot     = which ? b_plot     : a_plot;
    m_busy     = which ? b_busy     : a_busy;
    m_done     = which ? b_done     : a_done;
  end

  typedef struct {
    bit which;
    int sel;
    int xo;
    int yo;
    bit ke;
    int kc;
    int exp_plots;   // -1: take the count from the pixel model
    int exp_first;   // -1: no first-plot timing check
    bit repulse;
    bit pulse_done;
  } blit_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input bit w, input logic v);
    if (w) start_b = v;
    else   start_a = v;
  endtask

  task automatic run_blit(input blit_t b);
    int W, H, LAT, N, k_end, idx, lx, ly, col, sx, sy;
    int plots, first_k, done_cnt, done_k, mism, model_plots;
    bit vis, exp_busy;
    string first_bad;
    W = b.which ? 8 : 160;
    H = b.which ? 4 : 120;
    LAT = b.which ? 3 : 1;
    N = W * H;
    k_end = N + LAT + 2;
    plots = 0; first_k = -1; done_cnt = 0; done_k = -1; mism = 0; model_plots = 0;
    first_bad = "";
    @(negedge clock);
    which = b.which;
    #0;
    check("idle_busy", m_busy, 0);
    check("idle_plot", m_plot, 0);
    img_sel = 2'(b.sel); x_origin = 8'(b.xo); y_origin = 7'(b.yo);
    key_en = b.ke; key_col = 3'(b.kc);
    set_start(b.which, 1'b1);
    for (int k = 1; k <= k_end; k++) begin
      @(negedge clock);
      if (k == 1) begin
        set_start(b.which, 1'b0);
        check("busy_after_start", m_busy, 1);
        check("first_addr", m_rom_addr, 0);
        check("rom_sel", m_rom_sel, 64'(b.sel));
      end
      if (b.repulse && k == 100) set_start(b.which, 1'b1);
      if (b.repulse && k == 101) set_start(b.which, 1'b0);
      idx = k - LAT - 2;
      if (idx >= 0 && idx < N) begin
        lx  = idx % W;
        ly  = idx / W;
        col = (idx % 8) ^ b.sel;
        sx  = b.xo + lx;
        sy  = b.yo + ly;
        vis = (sx < 160) && (sy < 120) && !(b.ke && col == b.kc);
        if (vis) model_plots++;
        if (m_plot !== vis || m_out_x !== 8'(sx % 256) || m_out_y !== 7'(sy % 128) ||
            m_out_col !== 3'(col)) begin
          mism++;
          if (first_bad == "")
            first_bad = $sformatf("px%0d got p%0d(%0d,%0d)c%0d want p%0d(%0d,%0d)c%0d",
              idx, m_plot, m_out_x, m_out_y, m_out_col, vis, sx % 256, sy % 128, col);
        end
      end else if (m_plot !== 1'b0) begin
        mism++;
        if (first_bad == "") first_bad = $sformatf("stray plot at cycle %0d", k);
      end
      exp_busy = (k < k_end);
      if (m_busy !== exp_busy) begin
        mism++;
        if (first_bad == "") first_bad = $sformatf("busy %0d at cycle %0d", m_busy, k);
      end
      if (m_plot === 1'b1) begin
        plots++;
        if (first_k < 0) first_k = k;
      end
      if (m_done === 1'b1) begin
        done_cnt++;
        done_k = k;
      end
      if (b.pulse_done && k == k_end) set_start(b.which, 1'b1);
    end
    check($sformatf("pixels[%s]", first_bad), mism, 0);
    check("plot_count", plots, (b.exp_plots >= 0) ? b.exp_plots : model_plots);
    if (b.exp_first >= 0) check("first_plot_cycle", first_k, b.exp_first);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_k, k_end);
  endtask

  task automatic reset_mid_blit();
    int found, act;
    found = 0; act = 0;
    @(negedge clock);
    which = 1'b0;
    img_sel = 2'd1; x_origin = '0; y_origin = '0; key_en = 1'b0; key_col = '0;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    for (int c = 0; c < 6000 && found == 0; c++) begin
      if (a_rom_addr === 15'd5000) found = 1;
      else @(negedge clock);
    end
    check("reached_pixel_5000", found, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_plot", a_plot, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_addr", a_rom_addr, 0);
    check("rst_rom_sel", a_rom_sel, 0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (a_plot !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) act++;
    end
    check("post_reset_quiet", act, 0);
  endtask

  blit_t tbl[6];
  blit_t rb;

  initial begin
    // which sel xo yo ke kc plots first repulse pulse_done
    tbl[0] = '{0, 0, 0,   0,   0, 0, 19200, 3, 1, 1};
    tbl[1] = '{0, 2, 150, 115, 0, 0, 50,    3, 0, 0};
    tbl[2] = '{0, 0, 0,   0,   1, 3, 16800, 3, 0, 0};
    tbl[3] = '{1, 0, 0,   0,   0, 0, 32,    5, 0, 0};
    tbl[4] = '{1, 1, 156, 118, 0, 0, 8,     5, 0, 0};
    tbl[5] = '{1, 0, 0,   0,   1, 5, 28,    5, 0, 0};

    which = 1'b0; reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    img_sel = '0; x_origin = '0; y_origin = '0; key_en = 1'b0; key_col = '0;
    repeat (3) @(negedge clock);
    check("reset_addr", a_rom_addr, 0);
    check("reset_x", a_out_x, 0);
    check("reset_y", a_out_y, 0);
    check("reset_col", a_out_col, 0);
    check("reset_sel", a_rom_sel, 0);
    check("reset_flags", {a_plot, a_busy, a_done}, 0);
    check("reset_b", {b_rom_addr, b_out_x, b_out_y, b_out_col, b_rom_sel, b_plot, b_busy, b_done}, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (i == 2) reset_mid_blit();
      run_blit(tbl[i]);
    end

    for (int r = 0; r < 12; r++) begin
      rb.which = 1;
      rb.sel = int'($urandom_range(0, 3));
      rb.xo = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(150, 255));
      rb.yo = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(112, 127));
      rb.ke = 1'($urandom_range(0, 1));
      rb.kc = int'($urandom_range(0, 7));
      rb.exp_plots = -1;
      rb.exp_first = -1;
      rb.repulse = 0;
      rb.pulse_done = 1'($urandom_range(0, 1));
      run_blit(rb);
    end

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
